// File: rtl/scene_pkg.sv
// Shared timing, sprite and colour constants for the scene renderer,
// plus the coordinate type and the sprite box test.
package scene_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int SCALE_SHIFT = 2;

  localparam logic [9:0] PLAYER_W = 10'd8;
  localparam logic [9:0] PLAYER_H = 10'd8;
  localparam logic [9:0] ENEMY_W  = 10'd8;
  localparam logic [9:0] ENEMY_H  = 10'd8;
  localparam logic [9:0] BULLET_W = 10'd2;
  localparam logic [9:0] BULLET_H = 10'd4;

  localparam logic [11:0] COL_BULLET   = 12'hFFF;
  localparam logic [11:0] COL_PLAYER   = 12'hFF0;
  localparam logic [11:0] COL_ENEMY    = 12'hF00;
  localparam logic [11:0] COL_BG       = 12'h004;
  localparam logic [11:0] COL_INACTIVE = 12'h000;

  typedef logic [8:0] coord_t;

  // Widened to 10 bits so a box near coordinate 511 never wraps back to 0.
  function automatic logic in_box(input coord_t px, input coord_t py,
                                  input coord_t ox, input coord_t oy,
                                  input logic [9:0] w, input logic [9:0] h);
    logic [9:0] x10, y10, ox10, oy10;
    x10  = {1'b0, px};
    y10  = {1'b0, py};
    ox10 = {1'b0, ox};
    oy10 = {1'b0, oy};
    return (x10 >= ox10) && (x10 < ox10 + w) && (y10 >= oy10) && (y10 < oy10 + h);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster counters and the first pipeline stage: registered
// active flag, logical coordinates and raw syncs, plus the end-of-frame strobe.
module vga_timing
  import scene_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pix_en,
  output logic   o_active,
  output coord_t o_lx,
  output coord_t o_ly,
  output logic   o_hsync,
  output logic   o_vsync,
  output logic   o_eof
);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_active;
  coord_t     r_lx;
  coord_t     r_ly;
  logic       r_hsync;
  logic       r_vsync;

  logic w_h_last;
  logic w_v_last;

  assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));
  assign o_eof    = pix_en && w_h_last && w_v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_active <= 1'b0;
      r_lx     <= '0;
      r_ly     <= '0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
      r_active <= (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
      r_lx     <= coord_t'(r_h_cnt >> SCALE_SHIFT);
      r_ly     <= coord_t'(r_v_cnt >> SCALE_SHIFT);
      r_hsync  <= !((r_h_cnt >= 10'(H_SYNC_START)) && (r_h_cnt < 10'(H_SYNC_END)));
      r_vsync  <= !((r_v_cnt >= 10'(V_SYNC_START)) && (r_v_cnt < 10'(V_SYNC_END)));
    end
  end

  assign o_active = r_active;
  assign o_lx     = r_lx;
  assign o_ly     = r_ly;
  assign o_hsync  = r_hsync;
  assign o_vsync  = r_vsync;

endmodule

// File: rtl/scene_renderer.sv
// Per-frame position snapshot, sprite compositing onto the 160x120 canvas
// and once-per-frame bullet/enemy overlap report.
module scene_renderer
  import scene_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [8:0]  enemy_x,
  input  logic [8:0]  enemy_y,
  input  logic [8:0]  bullet_x,
  input  logic [8:0]  bullet_y,
  input  logic        exist_bullet,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        hit_pulse
);

  logic   w_active;
  coord_t w_lx;
  coord_t w_ly;
  logic   w_hsync;
  logic   w_vsync;
  logic   w_eof;

  vga_timing u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .o_active (w_active),
    .o_lx     (w_lx),
    .o_ly     (w_ly),
    .o_hsync  (w_hsync),
    .o_vsync  (w_vsync),
    .o_eof    (w_eof)
  );

  coord_t      r_player_x, r_player_y;
  coord_t      r_enemy_x, r_enemy_y;
  coord_t      r_bullet_x, r_bullet_y;
  logic        r_exist;
  logic        r_hit_acc;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;
  logic        r_frame_start;
  logic        r_hit_pulse;

  logic        w_in_player;
  logic        w_in_enemy;
  logic        w_in_bullet;
  logic [11:0] w_colour;

  assign w_in_player = in_box(w_lx, w_ly, r_player_x, r_player_y, PLAYER_W, PLAYER_H);
  assign w_in_enemy  = in_box(w_lx, w_ly, r_enemy_x, r_enemy_y, ENEMY_W, ENEMY_H);
  assign w_in_bullet = r_exist && in_box(w_lx, w_ly, r_bullet_x, r_bullet_y, BULLET_W, BULLET_H);

  always_comb begin
    w_colour = COL_INACTIVE;
    if (w_active) begin
      if (w_in_bullet)      w_colour = COL_BULLET;
      else if (w_in_player) w_colour = COL_PLAYER;
      else if (w_in_enemy)  w_colour = COL_ENEMY;
      else                  w_colour = COL_BG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_player_x    <= '0;
      r_player_y    <= '0;
      r_enemy_x     <= '0;
      r_enemy_y     <= '0;
      r_bullet_x    <= '0;
      r_bullet_y    <= '0;
      r_exist       <= 1'b0;
      r_hit_acc     <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_hit_pulse   <= 1'b0;
    end else begin
      r_frame_start <= w_eof;
      r_hit_pulse   <= w_eof && r_hit_acc;
      // The clear wins over a same-cycle overlap; S2 is in blanking then anyway.
      if (w_eof) begin
        r_player_x <= player_x;
        r_player_y <= player_y;
        r_enemy_x  <= enemy_x;
        r_enemy_y  <= enemy_y;
        r_bullet_x <= bullet_x;
        r_bullet_y <= bullet_y;
        r_exist    <= exist_bullet;
        r_hit_acc  <= 1'b0;
      end else if (pix_en && w_active && w_in_bullet && w_in_enemy) begin
        r_hit_acc <= 1'b1;
      end
      if (pix_en) begin
        r_rgb   <= w_colour;
        r_hsync <= w_hsync;
        r_vsync <= w_vsync;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;
  assign hit_pulse   = r_hit_pulse;

endmodule

// File: tb/tb_scene_renderer.sv
// Bench for scene_renderer: raster-position pixel scoreboard plus
// per-scenario timing, snapshot, priority/clip, hit and stall checks.
`timescale 1ns/1ps
module tb_scene_renderer;

  localparam int FRAME_CLKS = 420000;
  localparam int LINE_CLKS  = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [8:0]  player_x, player_y, enemy_x, enemy_y, bullet_x, bullet_y;
  logic        exist_bullet;
  logic        hsync, vsync, frame_start, hit_pulse;
  logic [11:0] rgb;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          f;
    int          v;
    int          h;
    logic [11:0] rgb;
  } probe_t;
  probe_t exp_q[$];

  // Reference raster position, kept independently of the DUT.
  int cur_h = 0, cur_v = 0, cur_f = 0;
  int p1_h = 0, p1_v = 0, p1_f = 0;
  int p2_h = 0, p2_v = 0, p2_f = 0;
  bit p1_ok = 0, p2_ok = 0, ticked = 0;

  scene_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .pix_en       (pix_en),
    .player_x     (player_x),
    .player_y     (player_y),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .exist_bullet (exist_bullet),
    .hsync        (hsync),
    .vsync        (vsync),
    .rgb          (rgb),
    .frame_start  (frame_start),
    .hit_pulse    (hit_pulse)
  );

  // ---------------- clock / reference position ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      cur_h = 0; cur_v = 0; cur_f = 0;
      p1_ok = 0; p2_ok = 0; ticked = 0;
    end else if (pix_en) begin
      p2_h = p1_h; p2_v = p1_v; p2_f = p1_f; p2_ok = p1_ok;
      p1_h = cur_h; p1_v = cur_v; p1_f = cur_f; p1_ok = 1;
      if (cur_h == LINE_CLKS - 1) begin
        cur_h = 0;
        if (cur_v == 524) begin
          cur_v = 0;
          cur_f = cur_f + 1;
        end else begin
          cur_v = cur_v + 1;
        end
      end else begin
        cur_h = cur_h + 1;
      end
      ticked = 1;
    end else begin
      ticked = 0;
    end
  end

  function automatic longint pkey(input int f, input int v, input int h);
    return longint'(f) * FRAME_CLKS + longint'(v) * LINE_CLKS + longint'(h);
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (ticked && p2_ok) begin
      while (exp_q.size() > 0 &&
             pkey(exp_q[0].f, exp_q[0].v, exp_q[0].h) < pkey(p2_f, p2_v, p2_h)) begin
        checks++;
        failures++;
        $display("FAIL pixel_missed f=%0d (h=%0d,v=%0d) never seen, expected rgb=%h",
                 exp_q[0].f, exp_q[0].h, exp_q[0].v, exp_q[0].rgb);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].f == p2_f && exp_q[0].v == p2_v && exp_q[0].h == p2_h) begin
        checks++;
        if (rgb !== exp_q[0].rgb) begin
          failures++;
          $display("FAIL pixel f=%0d (h=%0d,v=%0d) rgb=%h expected %h",
                   p2_f, p2_h, p2_v, rgb, exp_q[0].rgb);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_probe(input int f, input int v, input int h, input logic [11:0] c);
    probe_t p;
    p.f = f; p.v = v; p.h = h; p.rgb = c;
    exp_q.push_back(p);
  endtask

  task automatic set_cfg(input int px, input int py, input int ex, input int ey,
                         input int bx, input int by, input bit ex_b);
    player_x = 9'(px); player_y = 9'(py);
    enemy_x  = 9'(ex); enemy_y  = 9'(ey);
    bullet_x = 9'(bx); bullet_y = 9'(by);
    exist_bullet = ex_b;
  endtask

  task automatic wait_pos(input int f, input int v, input int h);
    int n = 0;
    while (!(cur_f > f || (cur_f == f && (cur_v > v || (cur_v == v && cur_h >= h))))
           && n < 2 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME_CLKS) begin
      failures++;
      $display("FAIL wait_pos timeout target f=%0d v=%0d h=%0d", f, v, h);
    end
  endtask

  task automatic wait_frame_start(input string name, input logic exp_hit);
    int n = 0;
    while (frame_start !== 1'b1 && n < FRAME_CLKS + 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_start not seen within %0d clks", name, n);
    end else if (hit_pulse !== exp_hit) begin
      failures++;
      $display("FAIL %s hit_pulse=%b expected %b", name, hit_pulse, exp_hit);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || hit_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s_width frame_start=%b hit_pulse=%b expected 0 0",
               name, frame_start, hit_pulse);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b1;
    set_cfg(0, 0, 159, 119, 159, 119, 1'b0);
    // Frame 0 draws the all-zero reset snapshot: every sprite at (0,0), no bullet.
    push_probe(0, 0, 0, 12'hFF0);
    push_probe(0, 0, 32, 12'h004);
    push_probe(0, 0, 640, 12'h000);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 ||
          frame_start !== 1'b0 || hit_pulse !== 1'b0) begin
        failures++;
        $display("FAIL reset rgb=%h hsync=%b vsync=%b fs=%b hit=%b expected 000 1 1 0 0",
                 rgb, hsync, vsync, frame_start, hit_pulse);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_player_box();
    push_probe(1, 0, 0, 12'hFF0);
    push_probe(1, 0, 31, 12'hFF0);
    push_probe(1, 0, 32, 12'h004);
    push_probe(1, 0, 640, 12'h000);
    push_probe(1, 31, 31, 12'hFF0);
    push_probe(1, 32, 0, 12'h004);
    push_probe(1, 479, 0, 12'h004);
    push_probe(1, 479, 635, 12'h004);
    push_probe(1, 479, 636, 12'hF00);
    push_probe(1, 479, 639, 12'hF00);
    push_probe(1, 480, 0, 12'h000);
  endtask

  task automatic test_timing();
    int n = 0, hs_low = 0, vs_low = 0, first_hs = -1;
    bit seen = 0;
    while (!seen && n < FRAME_CLKS + 1000) begin
      @(negedge clk);
      n++;
      if (frame_start === 1'b1) begin
        seen = 1;
      end else begin
        if (hsync === 1'b0) begin
          hs_low++;
          if (first_hs < 0) first_hs = n;
        end
        if (vsync === 1'b0) vs_low++;
      end
    end
    checks++;
    if (!seen || n != FRAME_CLKS) begin
      failures++;
      $display("FAIL first_frame_start at clk %0d (seen=%0d) expected %0d", n, seen, FRAME_CLKS);
    end
    checks++;
    if (hit_pulse !== 1'b0) begin
      failures++;
      $display("FAIL frame0_hit hit_pulse=%b expected 0", hit_pulse);
    end
    checks++;
    if (first_hs != 658) begin
      failures++;
      $display("FAIL hsync_first_low at clk %0d expected 658", first_hs);
    end
    checks++;
    if (hs_low != 525 * 96) begin
      failures++;
      $display("FAIL hsync_low_count %0d expected %0d", hs_low, 525 * 96);
    end
    checks++;
    if (vs_low != 1600) begin
      failures++;
      $display("FAIL vsync_low_count %0d expected 1600", vs_low);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL frame_start_width frame_start=%b expected 0", frame_start);
    end
  endtask

  task automatic test_snapshot();
    push_probe(2, 0, 0, 12'h004);
    push_probe(2, 0, 119, 12'h004);
    push_probe(2, 0, 120, 12'hFF0);
    push_probe(2, 0, 151, 12'hFF0);
    push_probe(2, 0, 152, 12'h004);
    push_probe(2, 31, 120, 12'hFF0);
    push_probe(2, 32, 120, 12'h004);
    wait_pos(1, 200, 0);
    player_x = 9'd30;
    // Frame 1 has bullet over enemy at (159,119) but no bullet exists.
    wait_frame_start("hit_f1_exist0", 1'b0);
  endtask

  task automatic test_priority_clip();
    push_probe(3, 15, 16, 12'hFF0);
    push_probe(3, 16, 15, 12'hFF0);
    push_probe(3, 16, 16, 12'hFFF);
    push_probe(3, 16, 23, 12'hFFF);
    push_probe(3, 16, 24, 12'hFF0);
    push_probe(3, 31, 23, 12'hFFF);
    push_probe(3, 32, 16, 12'h004);
    push_probe(3, 240, 0, 12'h004);
    push_probe(3, 240, 631, 12'h004);
    push_probe(3, 240, 632, 12'hF00);
    push_probe(3, 240, 639, 12'hF00);
    push_probe(3, 240, 640, 12'h000);
    push_probe(3, 271, 639, 12'hF00);
    push_probe(3, 272, 639, 12'h004);
    // Changed mid-frame 2; frame 2 must keep drawing the player at x=30.
    set_cfg(0, 0, 158, 60, 4, 4, 1'b1);
    wait_frame_start("hit_f2", 1'b0);
  endtask

  task automatic test_hit();
    push_probe(4, 200, 199, 12'h004);
    push_probe(4, 200, 200, 12'hF00);
    push_probe(4, 208, 207, 12'hF00);
    push_probe(4, 208, 208, 12'hFFF);
    push_probe(4, 208, 215, 12'hFFF);
    push_probe(4, 208, 216, 12'hF00);
    push_probe(4, 208, 231, 12'hF00);
    push_probe(4, 208, 232, 12'h004);
    set_cfg(0, 0, 50, 50, 52, 52, 1'b1);
    wait_frame_start("hit_f3_miss", 1'b0);
    push_probe(5, 200, 231, 12'hF00);
    push_probe(5, 200, 232, 12'h004);
    push_probe(5, 200, 240, 12'hFFF);
    push_probe(5, 200, 247, 12'hFFF);
    push_probe(5, 200, 248, 12'h004);
    set_cfg(0, 0, 50, 50, 60, 50, 1'b1);
    wait_frame_start("hit_f4_overlap", 1'b1);
    wait_frame_start("hit_f5_miss", 1'b0);
  endtask

  task automatic test_pix_en_stall();
    logic [11:0] hold_rgb;
    logic        hold_hs, hold_vs;
    push_probe(6, 200, 232, 12'h004);
    push_probe(6, 200, 240, 12'hFFF);
    wait_pos(6, 100, 655);
    hold_rgb = rgb;
    hold_hs  = hsync;
    hold_vs  = vsync;
    pix_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (rgb !== hold_rgb || hsync !== hold_hs || vsync !== hold_vs || frame_start !== 1'b0) begin
        failures++;
        $display("FAIL stall rgb=%h hs=%b vs=%b fs=%b expected %h %b %b 0",
                 rgb, hsync, vsync, frame_start, hold_rgb, hold_hs, hold_vs);
      end
    end
    pix_en = 1'b1;
    wait_pos(6, 210, 0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_player_box();
    test_timing();
    test_snapshot();
    test_priority_clip();
    test_hit();
    test_pix_en_stall();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain %0d probes left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
